// File: rtl/pe_mac_seq_if.sv
// pe_mac_seq_if: operand handshake, systolic forward and result bundle.
// The master drives operands, the slave is the PE.
interface pe_mac_seq_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W
);
  logic              en;
  logic              in_valid;
  logic              in_ready;
  logic              acc_mode;
  logic [DATA_W-1:0] A_in;
  logic [DATA_W-1:0] B_in;
  logic [DATA_W-1:0] A_out;
  logic [DATA_W-1:0] B_out;
  logic [ACC_W-1:0]  C_out;
  logic              start;
  logic              done;
  logic              ovf;

  modport master (
    output en, in_valid, acc_mode, A_in, B_in,
    input  in_ready, A_out, B_out, C_out,
    input  start, done, ovf
  );

  modport slave (
    input  en, in_valid, acc_mode, A_in, B_in,
    output in_ready, A_out, B_out, C_out,
    output start, done, ovf
  );
endinterface

// File: rtl/pe_mac_seq.sv
// pe_mac_seq: shift-add MAC PE with systolic A/B forward.
// Define PE_SAT_EN for saturating accumulate with sticky ovf.
module pe_mac_seq #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W,
  parameter bit SIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  pe_mac_seq_if.slave bus
);
  localparam int PW = 2*DATA_W;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ACC
  } state_t;

  state_t r_state, w_nxt;

  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_mcand;
  logic [PW-1:0]     r_pp;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_a_out;
  logic [DATA_W-1:0] r_b_out;
  logic [ACC_W-1:0]  r_c;
  logic              r_neg;
  logic              r_mode;
  logic              r_start;
  logic              r_done;

  logic              w_idle;
  logic              w_accept;
  logic              w_sa;
  logic              w_sb;
  logic [DATA_W-1:0] w_ma;
  logic [DATA_W-1:0] w_mb;
  logic [PW-1:0]     w_p;
  logic [ACC_W-1:0]  w_pext;
  logic [ACC_W-1:0]  w_acc;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = bus.en & bus.in_valid & w_idle;

  // |-2^(DATA_W-1)| still fits DATA_W bits as unsigned
  assign w_sa = SIGNED & bus.A_in[DATA_W-1];
  assign w_sb = SIGNED & bus.B_in[DATA_W-1];
  assign w_ma = w_sa ? -bus.A_in : bus.A_in;
  assign w_mb = w_sb ? -bus.B_in : bus.B_in;

  assign w_p    = r_neg ? -r_pp : r_pp;
  assign w_pext = SIGNED ? ACC_W'($signed(w_p))
                         : ACC_W'(w_p);

`ifdef PE_SAT_EN
  localparam logic [ACC_W-1:0] UMAX = '1;
  localparam logic [ACC_W-1:0] SMAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] w_sum;
  logic           w_sat;
  logic           r_ovf;

  assign w_sum = {1'b0, r_c} + {1'b0, w_pext};

  always_comb begin
    w_sat = 1'b0;
    w_acc = w_sum[ACC_W-1:0];
    if (SIGNED) begin
      if ((r_c[ACC_W-1] == w_pext[ACC_W-1]) &&
          (w_sum[ACC_W-1] != r_c[ACC_W-1])) begin
        w_sat = 1'b1;
        w_acc = r_c[ACC_W-1] ? SMIN : SMAX;
      end
    end else if (w_sum[ACC_W]) begin
      w_sat = 1'b1;
      w_acc = UMAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (bus.en) begin
      if (w_accept && !bus.acc_mode) begin
        r_ovf <= 1'b0;
      end else if ((r_state == S_ACC) &&
                   r_mode && w_sat) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.ovf = r_ovf;
`else
  assign w_acc   = r_c + w_pext;
  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (bus.en) begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (bus.in_valid) w_nxt = S_MUL;
      end
      (r_state == S_MUL): begin
        if (r_cnt == LAST) w_nxt = S_ACC;
      end
      (r_state == S_ACC): begin
        w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_pp     <= '0;
      r_mplier <= '0;
      r_a_out  <= '0;
      r_b_out  <= '0;
      r_c      <= '0;
      r_neg    <= 1'b0;
      r_mode   <= 1'b0;
      r_start  <= 1'b0;
      r_done   <= 1'b0;
    end else if (bus.en) begin
      r_start <= w_accept;
      r_done  <= (r_state == S_ACC);
      unique case (1'b1)
        w_accept: begin
          r_mcand  <= {{DATA_W{1'b0}}, w_ma};
          r_mplier <= w_mb;
          r_pp     <= '0;
          r_cnt    <= '0;
          r_neg    <= w_sa ^ w_sb;
          r_mode   <= bus.acc_mode;
          r_a_out  <= bus.A_in;
          r_b_out  <= bus.B_in;
        end
        (r_state == S_MUL): begin
          if (r_mplier[0]) r_pp <= r_pp + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        (r_state == S_ACC): begin
          r_c <= r_mode ? w_acc : w_pext;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = w_idle;
  assign bus.A_out    = r_a_out;
  assign bus.B_out    = r_b_out;
  assign bus.C_out    = r_c;
  assign bus.start    = r_start;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_pe_mac_seq.sv
// tb_pe_mac_seq: directed vectors on an unsigned and a signed PE
// driven in lockstep from one stimulus source.
module tb_pe_mac_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic       acc_mode;
  logic [7:0] a_in;
  logic [7:0] b_in;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_mac_seq_if #(.DATA_W(8), .ACC_W(16)) bu ();
  pe_mac_seq_if #(.DATA_W(8), .ACC_W(16)) bs ();

  assign bu.en       = en;
  assign bu.in_valid = in_valid;
  assign bu.acc_mode = acc_mode;
  assign bu.A_in     = a_in;
  assign bu.B_in     = b_in;
  assign bs.en       = en;
  assign bs.in_valid = in_valid;
  assign bs.acc_mode = acc_mode;
  assign bs.A_in     = a_in;
  assign bs.B_in     = b_in;

  pe_mac_seq #(
    .DATA_W(8), .ACC_W(16), .SIGNED(1'b0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bu)
  );

  pe_mac_seq #(
    .DATA_W(8), .ACC_W(16), .SIGNED(1'b1)
  ) u_sdut (
    .clk(clk), .rst_n(rst_n), .bus(bs)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // st_at/st_len: drop en for st_len clocks after st_at MUL edges
  task automatic op(input logic [7:0] a,
                    input logic [7:0] b,
                    input logic       m,
                    input int         st_at,
                    input int         st_len,
                    output int        lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bu.in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("rdy", bu.in_ready, 1);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    acc_mode = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("start_hi", bu.start, 1);
    chk("done_lo", bu.done, 0);
    lat = 0;
    while (!bu.done && lat < 40) begin
      if (lat == st_at && st_len > 0) begin
        en = 1'b0;
        repeat (st_len) @(posedge clk);
        #1;
        chk("stall_rdy", bu.in_ready, 0);
        en  = 1'b1;
        lat += st_len;
      end
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) chk("start_lo", bu.start, 0);
    end
    chk("rdy_in_done", bu.in_ready, 1);
  endtask

  initial begin
    int lat;
    int pulses;
    en       = 1'b1;
    in_valid = 1'b0;
    acc_mode = 1'b0;
    a_in     = 8'd0;
    b_in     = 8'd0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_c", bu.C_out, 0);
    chk("rst_a", bu.A_out, 0);
    chk("rst_b", bu.B_out, 0);
    chk("rst_start", bu.start, 0);
    chk("rst_done", bu.done, 0);
    chk("rst_ovf", bu.ovf, 0);
    chk("rst_rdy", bu.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(8'd5, 8'd8, 1'b0, -1, 0, lat);
    chk("t1_lat", lat, 9);
    chk("t1_c", bu.C_out, 40);
    chk("t1_aout", bu.A_out, 5);
    chk("t1_bout", bu.B_out, 8);

    op(8'd2, 8'd5, 1'b0, -1, 0, lat);
    chk("t2_c0", bu.C_out, 10);
    op(8'd8, 8'd7, 1'b1, -1, 0, lat);
    chk("t2_c1", bu.C_out, 66);
    op(8'd4, 8'd5, 1'b1, -1, 0, lat);
    chk("t2_c2", bu.C_out, 86);
    chk("t2_lat", lat, 9);

    op(8'd255, 8'd255, 1'b0, -1, 0, lat);
    chk("t3_c0", bu.C_out, 65025);
    chk("t3_ovf0", bu.ovf, 0);
    op(8'd255, 8'd255, 1'b1, -1, 0, lat);
`ifdef PE_SAT_EN
    chk("t3_c1", bu.C_out, 65535);
    chk("t3_ovf1", bu.ovf, 1);
`else
    chk("t3_c1", bu.C_out, 64514);
    chk("t3_ovf1", bu.ovf, 0);
`endif
    op(8'd1, 8'd1, 1'b0, -1, 0, lat);
    chk("t3_c2", bu.C_out, 1);
    chk("t3_ovf2", bu.ovf, 0);

    op(8'h80, 8'h80, 1'b0, -1, 0, lat);
    chk("t4_s0", bs.C_out, 16384);
    chk("t4_u0", bu.C_out, 16384);
    op(8'hFD, 8'd5, 1'b0, -1, 0, lat);
    chk("t4_s1", bs.C_out, 16'hFFF1);
    chk("t4_u1", bu.C_out, 1265);
    op(8'd7, 8'hFE, 1'b1, -1, 0, lat);
    chk("t4_s2", bs.C_out, 16'hFFE3);
    chk("t4_u2", bu.C_out, 3043);
    chk("t4_sovf", bs.ovf, 0);

    op(8'd29, 8'd121, 1'b0, 3, 5, lat);
    chk("t5_lat", lat, 14);
    chk("t5_c", bu.C_out, 3509);

    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 8'd3;
    b_in     = 8'd3;
    acc_mode = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("ab_busy", bu.in_ready, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_c", bu.C_out, 0);
    chk("ab_a", bu.A_out, 0);
    chk("ab_b", bu.B_out, 0);
    chk("ab_start", bu.start, 0);
    chk("ab_sc", bs.C_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ab_rdy", bu.in_ready, 1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bu.done) pulses++;
    end
    chk("ab_nodone", pulses, 0);
    chk("ab_c_hold", bu.C_out, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
